irq_priority_ctrl: RTL and testbench
====================================

IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 Parameter N, default 32, number of interrupt sources; SHALL be a power of two, >= 2.
REQ-002 Parameter IDW, default 5, width of interrupt ID; SHALL equal log2(N).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 irq_in  input  N  interrupt source lines, already synchronous to clk.
REQ-006 mask_we  input  1  mask register write strobe.
REQ-007 mask_wdata  input  N  mask write data; 1 = source enabled.
REQ-008 int_ack  input  1  CPU accepts the presented interrupt.
REQ-009 eret  input  1  CPU finished the handler.
REQ-010 mask_q  output  N  current mask register.
REQ-011 pending_q  output  N  current pending register.
REQ-012 int_req  output  1  interrupt request to CPU, registered.
REQ-013 int_id  output  IDW  index of presented source, registered.
REQ-014 int_onehot  output  N  one-hot of presented source, registered.

Function
REQ-015 Edge detect: per bit, register irq_prev; rise = irq_in & ~irq_prev; pending[i] SHALL set on the clock edge where rise[i]=1.
REQ-016 Pending bits SHALL be sticky until cleared by acknowledge (REQ-021); an irq_in falling edge SHALL not clear them.
REQ-017 Same bit, same cycle, set and clear: set SHALL win, and the bit remains 1.
REQ-018 Eligible vector e = pending_q & mask_q; priority is fixed, with bit 0 highest; the selection SHALL be the lowest set index, computed as one-hot = p & ~(p<<1) where p is the prefix-OR of e from bit 0 upward.
REQ-019 FSM states: IDLE, REQ, SERVICE.
REQ-020 IDLE: when e != 0, on the next edge load int_onehot and int_id from the selection, set int_req=1, and go to REQ; otherwise stay, with int_req=0.
REQ-021 REQ: int_req, int_id and int_onehot SHALL hold stable until int_ack=1; on the ack edge, clear pending[int_id], drive int_req=0, and go to SERVICE.
REQ-022 REQ: masking or the arrival of a higher-priority source SHALL NOT withdraw or change the presented request; no preemption.
REQ-023 SERVICE: on eret=1 go to IDLE; int_id and int_onehot keep the last value; new pending bits accumulate.
REQ-024 int_ack outside REQ, and eret outside SERVICE, SHALL be ignored.
REQ-025 Latency: if irq_in[i] is first sampled high at edge k with the bit enabled in IDLE, pending[i]=1 after edge k, and int_req=1, int_id=i after edge k+1.
REQ-026 Back-to-back: if e != 0 in IDLE right after eret, the next request SHALL assert one cycle after entering IDLE.
REQ-027 mask_we=1 SHALL load mask_q on the edge; the new mask affects selection from the following cycle.
REQ-028 Pending bits of masked sources SHALL still set, and SHALL be presented once unmasked.

Reset
REQ-029 With rst_n=0, immediately and asynchronously: state=IDLE, pending_q=0, mask_q=0, irq_prev=0, int_req=0, int_id=0, int_onehot=0.
REQ-030 Reset mid-REQ or mid-SERVICE SHALL abandon the transaction with no ack required; after release, an irq_in held high SHALL count as a new rising edge.

Verification
REQ-031 mask=all-ones; pulse irq_in[5] for 1 cycle -> pending_q[5]=1 the next cycle, then int_req=1, int_id=5, int_onehot=0x20; ack -> pending_q=0, int_req=0.
REQ-032 irq_in[3] and irq_in[9] rise together -> int_id=3; ack, eret -> int_id=9 one cycle after IDLE is re-entered.
REQ-033 mask=0; raise irq_in[7] -> pending_q[7]=1, int_req stays 0; write mask bit 7 -> int_req=1, int_id=7 two edges after the write.
REQ-034 In REQ presenting id 4, raise irq_in[0] and clear mask bit 4 -> int_id stays 4 until ack; after eret, id 0 is presented.
REQ-035 irq_in[2] re-rises on the same edge as the ack of id 2 -> pending_q[2] remains 1; after eret, id 2 is presented again.
REQ-036 Assert rst_n=0 in SERVICE with pending_q=0x11 -> all outputs 0 and state IDLE at once; a held irq_in[0] is re-detected after release.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Purpose: fixed-priority interrupt controller (bit 0 highest) with edge-detected sticky pending bits and mask register.
// Latency: irq_in rise sampled at edge k -> pending at k, int_req/int_id registered at k+1 when idle and enabled.
// Backpressure: a presented request holds stable until int_ack; no new request until eret returns the FSM to IDLE.
module irq_priority_ctrl #(
    parameter int N   = 32,
    parameter int IDW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   irq_in,
    input  logic           mask_we,
    input  logic [N-1:0]   mask_wdata,
    input  logic           int_ack,
    input  logic           eret,
    output logic [N-1:0]   mask_q,
    output logic [N-1:0]   pending_q,
    output logic           int_req,
    output logic [IDW-1:0] int_id,
    output logic [N-1:0]   int_onehot
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   irq_prev;
    logic [N-1:0]   rise;
    logic [N-1:0]   eligible;
    logic [N-1:0]   prefix;
    logic [N-1:0]   sel_onehot;
    logic [IDW-1:0] sel_id;
    logic [N-1:0]   ack_clr;
    logic           load_req;
    logic           take_ack;

    assign rise     = irq_in & ~irq_prev;
    assign eligible = pending_q & mask_q;

    // Prefix-OR from bit 0 upward; the first set position is the winner.
    always_comb begin
        prefix[0] = eligible[0];
        for (int i = 1; i < N; i++) begin
            prefix[i] = prefix[i-1] | eligible[i];
        end
    end

    assign sel_onehot = prefix & ~(prefix << 1);

    // Encode the one-hot winner into a binary index.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                sel_id = sel_id | IDW'(i);
            end
        end
    end

    // Next-state and transaction strobes; ack/eret are only honoured in their own state.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        take_ack  = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    load_req  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (int_ack) begin
                    take_ack  = 1'b1;
                    state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The presented one-hot equals the one-hot of int_id, so it doubles as the clear vector.
    assign ack_clr = take_ack ? int_onehot : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Edge history, sticky pending bits (a new rise beats a same-cycle clear) and mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev  <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            irq_prev  <= irq_in;
            pending_q <= (pending_q & ~ack_clr) | rise;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Registered request outputs; id/onehot keep their last value after the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req    <= 1'b0;
            int_id     <= '0;
            int_onehot <= '0;
        end else begin
            if (load_req) begin
                int_req    <= 1'b1;
                int_id     <= sel_id;
                int_onehot <= sel_onehot;
            end else if (take_ack) begin
                int_req    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Purpose: self-checking bench for irq_priority_ctrl: directed vector table, corner sequences, random vs reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: bench drives int_ack/eret directly, both in fixed patterns and randomly.
module tb_irq_priority_ctrl;

    localparam int N   = 32;
    localparam int IDW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   irq_in;
    logic           mask_we;
    logic [N-1:0]   mask_wdata;
    logic           int_ack;
    logic           eret;
    logic [N-1:0]   mask_q;
    logic [N-1:0]   pending_q;
    logic           int_req;
    logic [IDW-1:0] int_id;
    logic [N-1:0]   int_onehot;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending set, mask, last sample, and a "presenting"/"in handler" view of the CPU handshake.
    logic [N-1:0] m_pend, m_mask, m_prev, m_oh;
    logic         m_req, m_svc;
    int           m_id;

    irq_priority_ctrl #(.N(N), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_ack    (int_ack),
        .eret       (eret),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_onehot (int_onehot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   irq;
        logic           mwe;
        logic [N-1:0]   mwd;
        logic           ack;
        logic           ert;
        logic           req;
        logic [IDW-1:0] id;
        logic [N-1:0]   oh;
        logic [N-1:0]   pend;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                                input logic ack, input logic ert, input logic req,
                                input logic [IDW-1:0] id, input logic [N-1:0] oh, input logic [N-1:0] pend);
        vec_t v;
        v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.ert = ert;
        v.req = req; v.id = id; v.oh = oh; v.pend = pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_prev = '0; m_oh = '0;
        m_req  = 1'b0; m_svc = 1'b0; m_id = 0;
    endtask

    // One clock edge of the rules: lowest enabled pending index wins, ack clears it, a new rise always sets.
    task automatic model_edge();
        logic [N-1:0] e;
        logic [N-1:0] nxt;
        int low;
        e   = m_pend & m_mask;
        nxt = m_pend;
        if (m_req) begin
            if (int_ack) begin
                nxt[m_id] = 1'b0;
                m_req = 1'b0;
                m_svc = 1'b1;
            end
        end else if (m_svc) begin
            if (eret) m_svc = 1'b0;
        end else if (e != '0) begin
            low = 0;
            for (int i = N - 1; i >= 0; i--) if (e[i]) low = i;
            m_id  = low;
            m_oh  = '0;
            m_oh[low] = 1'b1;
            m_req = 1'b1;
        end
        nxt    = nxt | (irq_in & ~m_prev);
        m_pend = nxt;
        if (mask_we) m_mask = mask_wdata;
        m_prev = irq_in;
    endtask

    task automatic compare_model();
        check("model_req",     {{(N-1){1'b0}}, int_req}, {{(N-1){1'b0}}, m_req});
        check("model_id",      N'(int_id), N'(m_id));
        check("model_onehot",  int_onehot, m_oh);
        check("model_pending", pending_q, m_pend);
        check("model_mask",    mask_q, m_mask);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [N-1:0] irq, input logic mwe, input logic [N-1:0] mwd,
                         input logic ack, input logic ert);
        irq_in = irq; mask_we = mwe; mask_wdata = mwd; int_ack = ack; eret = ert;
    endtask

    // Asserts reset away from the clock edge, checks the asynchronous clear, releases on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [IDW-1:0] id, input logic [N-1:0] pend);
        check({tag, "_req"},  {{(N-1){1'b0}}, int_req}, {{(N-1){1'b0}}, req});
        check({tag, "_id"},   N'(int_id), N'(id));
        check({tag, "_pend"}, pending_q, pend);
    endtask

    initial begin
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        do_reset();
        check("reset_req",    {{(N-1){1'b0}}, int_req}, '0);
        check("reset_onehot", int_onehot, '0);
        check("reset_mask",   mask_q, '0);

        // Directed table: single pulse, simultaneous rises, ack/re-rise collision, ignored strobes.
        tv[0]  = mk(32'h0,   1, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 32'h0,   32'h0);
        tv[1]  = mk(32'h20,  0, 32'h0, 0, 0, 0, 5'd0, 32'h0,   32'h20);
        tv[2]  = mk(32'h0,   0, 32'h0, 0, 0, 1, 5'd5, 32'h20,  32'h20);
        tv[3]  = mk(32'h0,   0, 32'h0, 0, 0, 1, 5'd5, 32'h20,  32'h20);
        tv[4]  = mk(32'h0,   0, 32'h0, 1, 0, 0, 5'd5, 32'h20,  32'h0);
        tv[5]  = mk(32'h0,   0, 32'h0, 0, 0, 0, 5'd5, 32'h20,  32'h0);
        tv[6]  = mk(32'h0,   0, 32'h0, 0, 1, 0, 5'd5, 32'h20,  32'h0);
        tv[7]  = mk(32'h208, 0, 32'h0, 0, 0, 0, 5'd5, 32'h20,  32'h208);
        tv[8]  = mk(32'h208, 0, 32'h0, 0, 0, 1, 5'd3, 32'h8,   32'h208);
        tv[9]  = mk(32'h208, 0, 32'h0, 1, 0, 0, 5'd3, 32'h8,   32'h200);
        tv[10] = mk(32'h208, 0, 32'h0, 0, 1, 0, 5'd3, 32'h8,   32'h200);
        tv[11] = mk(32'h208, 0, 32'h0, 0, 0, 1, 5'd9, 32'h200, 32'h200);
        tv[12] = mk(32'h208, 0, 32'h0, 1, 0, 0, 5'd9, 32'h200, 32'h0);
        tv[13] = mk(32'h0,   0, 32'h0, 0, 1, 0, 5'd9, 32'h200, 32'h0);
        tv[14] = mk(32'h4,   0, 32'h0, 0, 0, 0, 5'd9, 32'h200, 32'h4);
        tv[15] = mk(32'h0,   0, 32'h0, 0, 0, 1, 5'd2, 32'h4,   32'h4);
        tv[16] = mk(32'h4,   0, 32'h0, 1, 0, 0, 5'd2, 32'h4,   32'h4);
        tv[17] = mk(32'h4,   0, 32'h0, 0, 1, 0, 5'd2, 32'h4,   32'h4);
        tv[18] = mk(32'h4,   0, 32'h0, 0, 0, 1, 5'd2, 32'h4,   32'h4);
        tv[19] = mk(32'h4,   0, 32'h0, 1, 0, 0, 5'd2, 32'h4,   32'h0);
        tv[20] = mk(32'h0,   0, 32'h0, 0, 1, 0, 5'd2, 32'h4,   32'h0);
        tv[21] = mk(32'h0,   0, 32'h0, 1, 1, 0, 5'd2, 32'h4,   32'h0);

        for (int i = 0; i < 22; i++) begin
            drive(tv[i].irq, tv[i].mwe, tv[i].mwd, tv[i].ack, tv[i].ert);
            step();
            chk_out($sformatf("tv%0d", i), tv[i].req, tv[i].id, tv[i].pend);
            check($sformatf("tv%0d_onehot", i), int_onehot, tv[i].oh);
        end

        // Masked source: pending sets, request appears two edges after the mask write.
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        drive(32'h80, 0, '0, 0, 0); step();
        chk_out("mask_pend", 1'b0, 5'd0, 32'h80);
        step();
        chk_out("mask_hold", 1'b0, 5'd0, 32'h80);
        drive(32'h80, 1, 32'h80, 0, 0); step();
        chk_out("mask_wr", 1'b0, 5'd0, 32'h80);
        check("mask_wr_q", mask_q, 32'h80);
        drive(32'h80, 0, '0, 0, 0); step();
        chk_out("mask_req", 1'b1, 5'd7, 32'h80);

        // No preemption: higher-priority arrival and masking of the presented source do not disturb it.
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        drive(32'h0, 1, '1, 0, 0);          step();
        drive(32'h10, 0, '0, 0, 0);         step();
        drive(32'h10, 0, '0, 0, 0);         step();
        chk_out("np_req", 1'b1, 5'd4, 32'h10);
        drive(32'h11, 1, ~32'h10, 0, 0);    step();
        chk_out("np_hold1", 1'b1, 5'd4, 32'h11);
        drive(32'h11, 0, '0, 0, 0);         step();
        chk_out("np_hold2", 1'b1, 5'd4, 32'h11);
        check("np_onehot", int_onehot, 32'h10);
        drive(32'h11, 0, '0, 1, 0);         step();
        chk_out("np_ack", 1'b0, 5'd4, 32'h01);
        drive(32'h11, 0, '0, 0, 1);         step();
        drive(32'h11, 0, '0, 0, 0);         step();
        chk_out("np_next", 1'b1, 5'd0, 32'h01);

        // Reset while in SERVICE with bits pending; held source must be re-detected afterwards.
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        drive(32'h0, 1, '1, 0, 0);          step();
        drive(32'h1, 0, '0, 0, 0);          step();
        drive(32'h1, 0, '0, 0, 0);          step();
        drive(32'h0, 0, '0, 1, 0);          step();
        drive(32'h11, 0, '0, 0, 0);         step();
        chk_out("rs_svc", 1'b0, 5'd0, 32'h11);
        rst_n = 1'b0;
        #1;
        chk_out("rs_async", 1'b0, 5'd0, 32'h0);
        check("rs_async_oh", int_onehot, '0);
        check("rs_async_mask", mask_q, '0);
        do_reset();
        drive(32'h11, 1, '1, 0, 0);         step();
        chk_out("rs_redetect", 1'b0, 5'd0, 32'h11);
        drive(32'h11, 0, '0, 0, 0);         step();
        chk_out("rs_req", 1'b1, 5'd0, 32'h11);

        // Randomized traffic against the reference model, with occasional mid-flight resets.
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end
            irq_in     = irq_in ^ ($urandom & $urandom & $urandom & $urandom);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = $urandom | $urandom;
            int_ack    = ($urandom_range(0, 2) == 0);
            eret       = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
